// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared func3 codes, FSM state type and byte-lane helpers for
//               the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_RD     = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [2:0] func3);
    logic [3:0] r_sz;
    case (func3[1:0])
      2'b00:   r_sz = 4'd1;
      2'b01:   r_sz = 4'd2;
      2'b10:   r_sz = 4'd4;
      default: r_sz = 4'd8;
    endcase
    return r_sz;
  endfunction

  // Lanes shifted past byte 7 fall off the top and are simply not selected.
  function automatic logic [7:0] lane_mask(input logic [2:0] offset,
                                           input logic [2:0] func3);
    logic [15:0] r_m;
    case (func3[1:0])
      2'b00:   r_m = 16'h0001;
      2'b01:   r_m = 16'h0003;
      2'b10:   r_m = 16'h000F;
      default: r_m = 16'h00FF;
    endcase
    r_m = r_m << offset;
    return r_m[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : DEPTH_WORDS x 64 single-port RAM, synchronous read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int    DEPTH_WORDS = 512,
  parameter string INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [63:0]                    wdata,
  output logic [63:0]                    rdata
);

  logic [63:0] r_mem [DEPTH_WORDS];
  logic [63:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    if (en) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Load/store responder over a 64-bit synchronous RAM with
//               read-modify-write partial stores and sign/zero extension.
//               Define DMEM_MISALIGN_TRAP_EN to make misaligned accesses errors.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 512,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ready_en;
  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [2:0]  r_func3;
  logic [63:0] r_rdata;
  logic        r_err;
  logic [63:0] r_merge;

  logic          w_mem_en;
  logic          w_mem_we;
  logic [63:0]   w_mem_rdata;
  logic [AW-1:0] w_mem_addr;

  logic [3:0]  w_size;
  logic        w_oob;
  logic        w_mis;
  logic        w_err;
  logic        w_sgn;
  logic [63:0] w_shift;
  logic [63:0] w_load;
  logic [7:0]  w_mask;
  logic [63:0] w_wshift;
  logic [63:0] w_merge;

  assign w_mem_addr = r_addr[AW+2:3];
  assign w_size     = size_bytes(r_func3);
  assign w_oob      = (r_addr[63:AW+3] != '0);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis = |(r_addr[2:0] & 3'(w_size - 4'd1));
`else
  assign w_mis = 1'b0;
`endif

  assign w_err = (r_func3 == F3_ILL) | (r_we & r_func3[2]) | w_oob | w_mis;

  // Load path: bring the addressed byte to lane 0; lanes past byte 7 read as 0.
  assign w_sgn   = ~r_func3[2];
  assign w_shift = w_mem_rdata >> {r_addr[2:0], 3'b000};

  always_comb begin
    w_load = w_shift;
    case (w_size)
      4'd1:    w_load = {{56{w_sgn & w_shift[7]}},  w_shift[7:0]};
      4'd2:    w_load = {{48{w_sgn & w_shift[15]}}, w_shift[15:0]};
      4'd4:    w_load = {{32{w_sgn & w_shift[31]}}, w_shift[31:0]};
      default: w_load = w_shift;
    endcase
  end

  assign w_mask   = lane_mask(r_addr[2:0], r_func3);
  assign w_wshift = r_wdata << {r_addr[2:0], 3'b000};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign w_merge[8*gi +: 8] = w_mask[gi] ? w_wshift[8*gi +: 8]
                                             : w_mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          w_state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        w_mem_en    = ~w_err;
        w_state_nxt = w_err ? S_RESP : S_RD;
      end
      S_RD: begin
        w_state_nxt = r_we ? S_WR : S_RESP;
      end
      S_WR: begin
        w_mem_we    = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ready_en <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_func3    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_merge    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ready_en <= 1'b1;
      if (r_state == S_IDLE && req_valid && req_ready) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_func3 <= req_func3;
      end
      if (r_state == S_ACCEPT) begin
        r_err   <= w_err;
        r_rdata <= '0;
      end
      if (r_state == S_RD) begin
        if (!r_we) begin
          r_rdata <= w_load;
        end
        r_merge <= w_merge;
      end
    end
  end

  // ready is held off for one edge after reset release
  assign req_ready = r_ready_en & (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = rsp_valid ? r_rdata : 64'd0;
  assign rsp_err   = rsp_valid & r_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .en    (w_mem_en),
    .we    (w_mem_we),
    .addr  (w_mem_addr),
    .wdata (r_merge),
    .rdata (w_mem_rdata)
  );

endmodule
`default_nettype wire
